// File: rtl/id_stage_pkg.sv
// Shared widths, ALU one-hot bit positions, MIPS opcode/function constants and
// bus structs for the decode stage.
package id_stage_pkg;
  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int DS_TO_ES_BUS_WD = 136;
  localparam int BR_BUS_WD       = 33;
  localparam int WS_TO_RF_BUS_WD = 38;
  localparam int ES_FWD_BUS_WD   = 39;
  localparam int MS_FWD_BUS_WD   = 38;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        load_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_8;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_to_es_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ws_to_rf_t;

  typedef struct packed {
    logic        we;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] result;
  } es_fwd_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_fwd_t;

  // A producing stage only forwards real writes; r0 is never a forwarding target.
  function automatic logic fwd_hit(input logic we, input logic [4:0] dest, input logic [4:0] src);
    return we && (dest != 5'd0) && (dest == src);
  endfunction
endpackage

// File: rtl/id_stage_if.sv
// Fetch/execute/writeback-facing signals of the decode stage.
interface id_stage_if;
  import id_stage_pkg::*;

  logic      es_allowin;
  logic      ds_allowin;
  logic      fs_to_ds_valid;
  fs_to_ds_t fs_to_ds_bus;
  logic      ds_to_es_valid;
  ds_to_es_t ds_to_es_bus;
  br_t       br_bus;
  ws_to_rf_t ws_to_rf_bus;
  es_fwd_t   es_fwd_bus;
  ms_fwd_t   ms_fwd_bus;

  modport slave (
    input  es_allowin, fs_to_ds_valid, fs_to_ds_bus, ws_to_rf_bus, es_fwd_bus, ms_fwd_bus,
    output ds_allowin, ds_to_es_valid, ds_to_es_bus, br_bus
  );

  modport master (
    output es_allowin, fs_to_ds_valid, fs_to_ds_bus, ws_to_rf_bus, es_fwd_bus, ms_fwd_bus,
    input  ds_allowin, ds_to_es_valid, ds_to_es_bus, br_bus
  );
endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two combinational read ports, one write port, r0 hardwired to 0.
module id_stage_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] rf_q [32];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) rf_q[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf_q[raddr2];
endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: latches fetch output, decodes, reads/bypasses operands,
// detects load-use stalls and resolves branches back to fetch.
module id_stage
  import id_stage_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  id_stage_if.slave io
);
  logic      ds_valid_q, ds_valid_d;
  fs_to_ds_t ds_bus_q, ds_bus_d;
  logic      ds_ready_go, ds_allowin;

  logic [31:0] inst, pc, pc_plus4;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  assign inst = ds_bus_q.inst;
  assign pc   = ds_bus_q.pc;
  assign op   = inst[31:26];
  assign fn   = inst[5:0];
  assign rs   = inst[25:21];
  assign rt   = inst[20:16];
  assign rd   = inst[15:11];

  logic is_special;
  logic i_addu, i_subu, i_slt, i_sltu, i_and, i_or, i_xor, i_nor;
  logic i_sll, i_srl, i_sra, i_jr;
  logic i_addiu, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic r_alu, shift, reads_rs, reads_rt;

  assign is_special = (op == OP_SPECIAL);
  assign i_addu  = is_special & (fn == FN_ADDU);
  assign i_subu  = is_special & (fn == FN_SUBU);
  assign i_slt   = is_special & (fn == FN_SLT);
  assign i_sltu  = is_special & (fn == FN_SLTU);
  assign i_and   = is_special & (fn == FN_AND);
  assign i_or    = is_special & (fn == FN_OR);
  assign i_xor   = is_special & (fn == FN_XOR);
  assign i_nor   = is_special & (fn == FN_NOR);
  assign i_sll   = is_special & (fn == FN_SLL);
  assign i_srl   = is_special & (fn == FN_SRL);
  assign i_sra   = is_special & (fn == FN_SRA);
  assign i_jr    = is_special & (fn == FN_JR);
  assign i_addiu = (op == OP_ADDIU);
  assign i_lui   = (op == OP_LUI);
  assign i_lw    = (op == OP_LW);
  assign i_sw    = (op == OP_SW);
  assign i_beq   = (op == OP_BEQ);
  assign i_bne   = (op == OP_BNE);
  assign i_j     = (op == OP_J);
  assign i_jal   = (op == OP_JAL);

  assign r_alu    = i_addu | i_subu | i_slt | i_sltu | i_and | i_or | i_xor | i_nor;
  assign shift    = i_sll | i_srl | i_sra;
  // Only sources the instruction really consumes may trigger a load-use stall.
  assign reads_rs = r_alu | i_addiu | i_lw | i_sw | i_beq | i_bne | i_jr;
  assign reads_rt = r_alu | shift | i_sw | i_beq | i_bne;

  logic [11:0] alu_op;
  logic [4:0]  dest;
  always_comb begin
    alu_op           = '0;
    alu_op[ALU_ADD]  = i_addu | i_addiu | i_lw | i_sw | i_jal;
    alu_op[ALU_SUB]  = i_subu;
    alu_op[ALU_SLT]  = i_slt;
    alu_op[ALU_SLTU] = i_sltu;
    alu_op[ALU_AND]  = i_and;
    alu_op[ALU_NOR]  = i_nor;
    alu_op[ALU_OR]   = i_or;
    alu_op[ALU_XOR]  = i_xor;
    alu_op[ALU_SLL]  = i_sll;
    alu_op[ALU_SRL]  = i_srl;
    alu_op[ALU_SRA]  = i_sra;
    alu_op[ALU_LUI]  = i_lui;
    dest = 5'd0;
    if (r_alu | shift)               dest = rd;
    else if (i_addiu | i_lui | i_lw) dest = rt;
    else if (i_jal)                  dest = 5'd31;
  end

  logic [31:0] rf_rdata1, rf_rdata2, rs_value, rt_value;
  id_stage_regfile u_regfile (
    .clk    (clk),
    .raddr1 (rs),
    .rdata1 (rf_rdata1),
    .raddr2 (rt),
    .rdata2 (rf_rdata2),
    .we     (io.ws_to_rf_bus.we),
    .waddr  (io.ws_to_rf_bus.waddr),
    .wdata  (io.ws_to_rf_bus.wdata)
  );

  // Lowest priority first so the youngest producer wins.
  always_comb begin
    rs_value = rf_rdata1;
    rt_value = rf_rdata2;
    if (fwd_hit(io.ws_to_rf_bus.we, io.ws_to_rf_bus.waddr, rs)) rs_value = io.ws_to_rf_bus.wdata;
    if (fwd_hit(io.ws_to_rf_bus.we, io.ws_to_rf_bus.waddr, rt)) rt_value = io.ws_to_rf_bus.wdata;
    if (fwd_hit(io.ms_fwd_bus.we, io.ms_fwd_bus.dest, rs))      rs_value = io.ms_fwd_bus.result;
    if (fwd_hit(io.ms_fwd_bus.we, io.ms_fwd_bus.dest, rt))      rt_value = io.ms_fwd_bus.result;
    if (fwd_hit(io.es_fwd_bus.we, io.es_fwd_bus.dest, rs))      rs_value = io.es_fwd_bus.result;
    if (fwd_hit(io.es_fwd_bus.we, io.es_fwd_bus.dest, rt))      rt_value = io.es_fwd_bus.result;
  end

  logic load_use;
  assign load_use = io.es_fwd_bus.we & io.es_fwd_bus.is_load &
                    ((reads_rs & fwd_hit(1'b1, io.es_fwd_bus.dest, rs)) |
                     (reads_rt & fwd_hit(1'b1, io.es_fwd_bus.dest, rt)));
  assign ds_ready_go = ~(ds_valid_q & load_use);

  logic        br_cond, br_taken;
  logic [31:0] br_target;
  assign pc_plus4 = pc + 32'd4;
  assign br_cond  = (i_beq & (rs_value == rt_value)) | (i_bne & (rs_value != rt_value)) |
                    i_j | i_jal | i_jr;
  always_comb begin
    br_target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    if (i_jr)             br_target = rs_value;
    else if (i_j | i_jal) br_target = {pc_plus4[31:28], inst[25:0], 2'b00};
  end
  assign br_taken  = ds_valid_q & ds_ready_go & br_cond;
  assign io.br_bus = br_t'{br_taken, (br_taken ? br_target : 32'd0)};

  ds_to_es_t es_bus;
  always_comb begin
    es_bus             = '0;
    es_bus.alu_op      = alu_op;
    es_bus.load_op     = i_lw;
    es_bus.src1_is_sa  = shift;
    es_bus.src1_is_pc  = i_jal;
    es_bus.src2_is_imm = i_addiu | i_lui | i_lw | i_sw;
    es_bus.src2_is_8   = i_jal;
    es_bus.gr_we       = r_alu | shift | i_addiu | i_lui | i_lw | i_jal;
    es_bus.mem_we      = i_sw;
    es_bus.dest        = dest;
    es_bus.imm         = inst[15:0];
    es_bus.rs_value    = rs_value;
    es_bus.rt_value    = rt_value;
    es_bus.pc          = pc;
  end
  assign io.ds_to_es_bus = es_bus;

  assign ds_allowin        = ~ds_valid_q | (ds_ready_go & io.es_allowin);
  assign io.ds_allowin     = ds_allowin;
  assign io.ds_to_es_valid = ds_valid_q & ds_ready_go;

  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_bus_d   = ds_bus_q;
    if (ds_allowin)                     ds_valid_d = io.fs_to_ds_valid;
    if (ds_allowin & io.fs_to_ds_valid) ds_bus_d   = io.fs_to_ds_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) ds_valid_q <= 1'b0;
    else       ds_valid_q <= ds_valid_d;
  end

  // The payload register is only qualified by ds_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    ds_bus_q <= ds_bus_d;
  end
endmodule
